// File: rtl/wb_stream_master_if.sv
// Signal bundle for wb_stream_master: command/response byte streams plus the
// classic WISHBONE master port (22-bit address, 32-bit data).
interface wb_stream_master_if;
  logic [7:0]  cmd_tdata;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic [7:0]  rsp_tdata;
  logic        rsp_tvalid;
  logic        rsp_tready;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [21:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  modport master (
    input  cmd_tdata, cmd_tvalid, rsp_tready, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output cmd_tready, rsp_tdata, rsp_tvalid,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output cmd_tdata, cmd_tvalid, rsp_tready, wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  cmd_tready, rsp_tdata, rsp_tvalid,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/wb_stream_master.sv
// Byte-stream to classic WISHBONE bridge: framed commands become single bus cycles,
// status (and read data) return on the response stream. Define WB_TIMEOUT_EN for a bus timeout.
module wb_stream_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_stream_master_if.master bus
);

  localparam logic [2:0] ST_HDR      = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_WDATA    = 3'd2;
  localparam logic [2:0] ST_BUS      = 3'd3;
  localparam logic [2:0] ST_RSP_STAT = 3'd4;
  localparam logic [2:0] ST_RSP_DATA = 3'd5;

  logic [2:0]  state;
  logic [1:0]  cnt;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [21:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rdata;
  logic        cyc;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [21:0] wb_adr;
  logic [31:0] wb_dat;
  logic        rsp_valid;
  logic [7:0]  rsp_data;

  logic        cmd_ready;
  logic        cmd_fire;
  logic        rsp_fire;
  logic        term_any;
  logic        timeout_hit;
  logic [7:0]  status_next;

  assign cmd_ready = !rst_i && (state == ST_HDR || state == ST_ADDR || state == ST_WDATA);
  assign cmd_fire  = cmd_ready && bus.cmd_tvalid;
  assign rsp_fire  = rsp_valid && bus.rsp_tready;
  assign term_any  = bus.wb_ack_i || bus.wb_err_i || bus.wb_rty_i;

  // err beats rty beats ack; no termination at all can only mean a timeout
  always_comb begin
    status_next = 8'h00;
    if (bus.wb_err_i)       status_next = 8'h01;
    else if (bus.wb_rty_i)  status_next = 8'h03;
    else if (!bus.wb_ack_i) status_next = 8'h02;
  end

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || state != ST_BUS) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_BUS) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Parsing fills shadow registers; bus outputs only change when BUS is entered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_HDR;
      cnt       <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      rdata     <= '0;
      cyc       <= 1'b0;
      wb_we     <= 1'b0;
      wb_sel    <= '0;
      wb_adr    <= '0;
      wb_dat    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        ST_HDR: begin
          if (cmd_fire) begin
            we_q  <= bus.cmd_tdata[7];
            sel_q <= bus.cmd_tdata[3:0];
            cnt   <= '0;
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (cmd_fire) begin
            adr_q <= {adr_q[13:0], bus.cmd_tdata};
            if (cnt == 2'd2) begin
              cnt <= '0;
              if (we_q) begin
                state <= ST_WDATA;
              end else begin
                state  <= ST_BUS;
                cyc    <= 1'b1;
                wb_we  <= 1'b0;
                wb_sel <= sel_q;
                wb_adr <= {adr_q[13:0], bus.cmd_tdata};
              end
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        ST_WDATA: begin
          if (cmd_fire) begin
            dat_q <= {dat_q[23:0], bus.cmd_tdata};
            if (cnt == 2'd3) begin
              cnt    <= '0;
              state  <= ST_BUS;
              cyc    <= 1'b1;
              wb_we  <= 1'b1;
              wb_sel <= sel_q;
              wb_adr <= adr_q;
              wb_dat <= {dat_q[23:0], bus.cmd_tdata};
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        ST_BUS: begin
          if (term_any || timeout_hit) begin
            cyc       <= 1'b0;
            state     <= ST_RSP_STAT;
            rsp_valid <= 1'b1;
            rsp_data  <= status_next;
            rdata     <= (status_next == 8'h00) ? bus.wb_dat_i : 32'h0000_0000;
          end
        end
        ST_RSP_STAT: begin
          if (rsp_fire) begin
            if (we_q) begin
              rsp_valid <= 1'b0;
              state     <= ST_HDR;
            end else begin
              rsp_data <= rdata[31:24];
              rdata    <= {rdata[23:0], 8'h00};
              cnt      <= '0;
              state    <= ST_RSP_DATA;
            end
          end
        end
        ST_RSP_DATA: begin
          if (rsp_fire) begin
            if (cnt == 2'd3) begin
              rsp_valid <= 1'b0;
              cnt       <= '0;
              state     <= ST_HDR;
            end else begin
              rsp_data <= rdata[31:24];
              rdata    <= {rdata[23:0], 8'h00};
              cnt      <= cnt + 2'd1;
            end
          end
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  assign bus.cmd_tready = cmd_ready;
  assign bus.rsp_tvalid = rsp_valid;
  assign bus.rsp_tdata  = rsp_data;
  assign bus.wb_cyc_o   = cyc;
  assign bus.wb_stb_o   = cyc;
  assign bus.wb_we_o    = wb_we;
  assign bus.wb_sel_o   = wb_sel;
  assign bus.wb_adr_o   = wb_adr;
  assign bus.wb_dat_o   = wb_dat;

endmodule
